vga_frame_capture: RTL and testbench

Downstream consumer of the VGA pixel stream: sits beside the graphics stage and taps the same `pixel_x`/`pixel_y`/`video_on` timing plus the final RGB, capturing exactly one complete active frame on request. Captured pixels are buffered in an internal FIFO and presented on a valid/ready stream with start-of-frame and end-of-line markers, for frame dump, checksum or debug-link logic. Pixels that cannot be buffered are dropped and counted; the capture never stalls the display.

---
 rtl/vga_frame_capture.sv | 111 +++++++++++
 tb/tb_vga_frame_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// Taps the VGA pixel stream and captures exactly one active frame on request into a
// first-word fall-through FIFO, presented as a valid/ready stream with sof/eol marks.
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DEPTH    = 16
) (
  input  logic                   clock_50,
  input  logic                   reset,
  input  logic                   pixel_tick,
  input  logic                   video_on,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic [7:0]             pix_r,
  input  logic [7:0]             pix_g,
  input  logic [7:0]             pix_b,
  input  logic                   capture_req,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [23:0]            out_data,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // state    | meaning
  // IDLE     | not capturing; FIFO keeps draining
  // WAIT_SOF | armed, waiting for pixel (0,0)
  // CAPTURE  | writing every active pixel until the last one of the frame

  localparam int AW = $clog2(DEPTH);
  localparam logic [9:0]  H_LIM      = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
  localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;
  state_t state;

  logic [25:0]   mem [DEPTH];
  logic [25:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          at_origin, in_area, at_last, at_eol;
  logic          cap_event, pop, push;

  always_comb begin
    at_origin = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    in_area   = (pixel_x < H_LIM) && (pixel_y < V_LIM);
    at_eol    = (pixel_x == X_LAST);
    at_last   = at_eol && (pixel_y == Y_LAST);
    cap_event = pixel_tick & video_on &
                (((state == WAIT_SOF) & at_origin) | ((state == CAPTURE) & in_area));
    pop       = out_valid & out_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push      = cap_event & ((fifo_level != LEVEL_FULL) | pop);
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock_50) begin
    if (push) mem[wr_ptr] <= {pix_r, pix_g, pix_b, at_origin, at_eol};
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      frame_done <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push & ~pop)      fifo_level <= fifo_level + (AW + 1)'(1);
      else if (pop & ~push) fifo_level <= fifo_level - (AW + 1)'(1);

      case (state)
        IDLE: begin
          if (capture_req) begin
            state      <= WAIT_SOF;
            drop_count <= '0;
          end
        end
        WAIT_SOF, CAPTURE: begin
          if (cap_event & ~push & (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
          if (cap_event & at_last) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end else if (cap_event) begin
            state <= CAPTURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_level != '0);
  assign out_data  = head[25:2];
  assign out_sof   = out_valid & head[1];
  assign out_eol   = out_valid & head[0];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture on a shrunken raster, compared cycle by cycle against a
// queue-based reference of the capture rules.
module tb_vga_frame_capture;

  localparam int H  = 40;
  localparam int V  = 8;
  localparam int D  = 16;
  localparam int HT = 48;
  localparam int VT = 10;
  localparam int FRAME_CYC = HT * VT * 2;

  logic        clock_50 = 1'b0;
  logic        reset, pixel_tick, video_on, capture_req, out_ready;
  logic [9:0]  pixel_x, pixel_y;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        out_valid, out_sof, out_eol, busy, frame_done;
  logic [23:0] out_data;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;

  always #10 clock_50 = ~clock_50;

  vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(D)) dut (
    .clock_50(clock_50), .reset(reset), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .capture_req(capture_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .busy(busy),
    .frame_done(frame_done), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // raster generator
  int hc = 0, vc = 0;
  bit pattern_mode = 1'b1;
  bit rand_ready = 1'b0;

  task automatic drive_pixel();
    pixel_x  = 10'(hc);
    pixel_y  = 10'(vc);
    video_on = (hc < H) && (vc < V);
    if (pattern_mode) begin
      pix_r = 8'(hc); pix_g = 8'(vc); pix_b = 8'h5A;
    end else begin
      pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
    end
  endtask

  // reference model: capture rules expressed over a queue
  logic [25:0] q[$];
  bit armed = 0, capturing = 0, done_exp = 0;
  int drops = 0;
  int beats, eols, sofs, dones;
  logic [25:0] first_beat;
  int popped_r[$];

  task automatic clear_stats();
    beats = 0; eols = 0; sofs = 0; dones = 0; first_beat = '0; popped_r.delete();
  endtask

  task automatic model_update();
    bit idle0, ev, pop;
    logic [25:0] e;
    int px, py;
    px = int'(pixel_x);
    py = int'(pixel_y);
    done_exp = 0;
    if (reset) begin
      q.delete(); armed = 0; capturing = 0; drops = 0;
      return;
    end
    idle0 = !armed && !capturing;
    pop = (q.size() != 0) && out_ready;
    if (pop) begin
      e = q.pop_front();
      beats++;
      if (e[0]) eols++;
      if (e[1]) sofs++;
      if (beats == 1) first_beat = e;
      if (popped_r.size() < 32) popped_r.push_back(int'(e[25:18]));
    end
    ev = 0;
    if (pixel_tick && video_on && px < H && py < V)
      ev = capturing || (armed && px == 0 && py == 0);
    if (ev) begin
      if (q.size() < D) q.push_back({pix_r, pix_g, pix_b, px == 0 && py == 0, px == H - 1});
      else if (drops < 65535) drops++;
      armed = 0; capturing = 1;
      if (px == H - 1 && py == V - 1) begin
        capturing = 0; done_exp = 1; dones++;
      end
    end
    if (idle0 && capture_req) begin
      armed = 1; drops = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check_eq("fifo_level", 32'(fifo_level), 32'(q.size()));
    check_eq("busy", 32'(busy), 32'(armed || capturing));
    check_eq("frame_done", 32'(frame_done), 32'(done_exp));
    check_eq("drop_count", 32'(drop_count), 32'(drops));
    if (q.size() != 0) begin
      check_eq("out_data", 32'(out_data), 32'(q[0][25:2]));
      check_eq("out_sof", 32'(out_sof), 32'(q[0][1]));
      check_eq("out_eol", 32'(out_eol), 32'(q[0][0]));
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    model_update();
    #1;
    check_outputs();
    capture_req = 1'b0;
    reset = 1'b0;
    if (pixel_tick) begin
      hc++;
      if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
      drive_pixel();
    end
    pixel_tick = ~pixel_tick;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int d0, n;
    d0 = dones; n = 0;
    while (dones == d0 && n < 3 * FRAME_CYC) begin step(); n++; end
    check_eq(tag, 32'(dones != d0), 32'd1);
  endtask

  task automatic drain();
    int n;
    rand_ready = 0; out_ready = 1'b1; n = 0;
    while (q.size() != 0 && n < 4 * D) begin step(); n++; end
    check_eq("drain_empty", 32'(q.size()), 32'd0);
    step();
  endtask

  task automatic start_capture();
    capture_req = 1'b1;
    step();
    check_eq("busy_rise", 32'(busy), 32'd1);
  endtask

  initial begin
    int n, d0;
    bit seen_valid;
    reset = 1'b1; capture_req = 0; out_ready = 0; pixel_tick = 0;
    drive_pixel();
    clear_stats();

    // reset state and no traffic without a request
    step();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_drops", 32'(drop_count), 32'd0);
    check_eq("rst_sof_eol", 32'({out_sof, out_eol}), 32'd0);
    out_ready = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < FRAME_CYC + 50; i++) begin step(); seen_valid |= out_valid; end
    check_eq("idle_no_valid", 32'(seen_valid), 32'd0);

    // full capture, request mid-frame, extra request during CAPTURE is ignored
    n = 0;
    while (vc != 3 && n < FRAME_CYC) begin step(); n++; end
    clear_stats();
    start_capture();
    n = 0;
    while (!(capturing && vc == 2) && n < 2 * FRAME_CYC) begin step(); n++; end
    capture_req = 1'b1;
    step();
    wait_done("full_done_timeout");
    drain();
    check_eq("full_beats", 32'(beats), 32'(H * V));
    check_eq("full_eols", 32'(eols), 32'(V));
    check_eq("full_sofs", 32'(sofs), 32'd1);
    check_eq("full_first_data", 32'(first_beat[25:2]), 32'h00005A);
    check_eq("full_first_sof", 32'(first_beat[1]), 32'd1);
    check_eq("full_done_count", 32'(dones), 32'd1);
    check_eq("full_drops", 32'(drop_count), 32'd0);

    // backpressure through line 0
    clear_stats();
    out_ready = 1'b0;
    start_capture();
    n = 0;
    while (!(capturing && vc == 1) && n < 2 * FRAME_CYC) begin step(); n++; end
    check_eq("bp_drops_line0", 32'(drop_count), 32'(H - D));
    out_ready = 1'b1;
    wait_done("bp_done_timeout");
    drain();
    check_eq("bp_drops_final", 32'(drop_count), 32'(H - D));
    check_eq("bp_beats", 32'(beats), 32'(H * V - (H - D)));
    for (int i = 0; i < D; i++) check_eq($sformatf("bp_order_%0d", i), 32'(popped_r[i]), 32'(i));

    // full FIFO with a pop on a capture cycle
    pattern_mode = 0;
    clear_stats();
    out_ready = 1'b0;
    start_capture();
    n = 0;
    while (!(capturing && q.size() == D && pixel_tick && video_on) && n < 2 * FRAME_CYC) begin
      step(); n++;
    end
    d0 = drop_count;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("fullpop_level", 32'(fifo_level), 32'(D));
    check_eq("fullpop_drops", 32'(drop_count), 32'(d0));
    out_ready = 1'b1;
    wait_done("fullpop_done_timeout");
    drain();

    // reset in the middle of a capture with 8 entries buffered
    clear_stats();
    out_ready = 1'b0;
    start_capture();
    n = 0;
    while (!(capturing && q.size() == 8) && n < 2 * FRAME_CYC) begin step(); n++; end
    reset = 1'b1;
    step();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_level", 32'(fifo_level), 32'd0);
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_done", 32'(frame_done), 32'd0);
    for (int i = 0; i < FRAME_CYC; i++) step();
    check_eq("midrst_no_done", 32'(dones), 32'd0);

    // random colours and random backpressure, back-to-back captures
    for (int f = 0; f < 2; f++) begin
      clear_stats();
      out_ready = 1'b1;
      start_capture();
      rand_ready = 1;
      wait_done("rand_done_timeout");
      d0 = drop_count;
      drain();
      check_eq("rand_accounting", 32'(beats + d0), 32'(H * V));
      check_eq("rand_first_sof", 32'(first_beat[1]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
